// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  fifo_pkg
//  Shared constants and width helpers for the single-clock FIFO.
//  Revision: 1.0
// ============================================================================
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Pointer/count width: one extra bit so full and empty remain distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  fifo_mem
//  Simple dual-port RAM, DEPTH x DATA_W: synchronous write, asynchronous read.
//  Revision: 1.0
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  sync_fifo_param
//  Single-clock FIFO with occupancy count, thresholds, sticky error flags and
//  selectable standard (registered) or first-word-fall-through read.
//  Revision: 1.0
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wreq,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   wfull,
    output logic                   walmost_full,
    input  logic                   rreq,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rvalid,
    output logic                   rempty,
    output logic                   ralmost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [AW:0] c_depth = PW'(DEPTH);
    localparam logic [AW:0] c_af    = PW'(AF_THRESH);
    localparam logic [AW:0] c_ae    = PW'(AE_THRESH);
    localparam logic [AW:0] c_one   = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wptr_q, rptr_q, count_q, count_d;
    logic              overflow_q, underflow_q;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags come only from the registered count, so same-cycle traffic never
    // frees a slot for a write when full or feeds a read when empty.
    assign wfull         = (count_q == c_depth);
    assign walmost_full  = (count_q >= c_af);
    assign rempty        = (count_q == '0);
    assign ralmost_empty = (count_q <= c_ae);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    assign wr_acc = wreq & ~wfull;
    assign rd_acc = rreq & ~rempty;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + c_one;
            if (rd_acc) rptr_q <= rptr_q + c_one;
            count_q     <= count_d;
            overflow_q  <= overflow_q  | (wreq & wfull);
            underflow_q <= underflow_q | (rreq & rempty);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so the
            // output stays stable instead of exposing stale RAM contents.
            assign rdata  = rempty ? '0 : mem_rdata;
            assign rvalid = ~rempty;
        end else begin : g_std
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem_rdata;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    // Occupancy must always equal the modular pointer distance.
    a_count_ptr: assert property (@(posedge clk) disable iff (rst)
        count_q == (wptr_q - rptr_q));

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  tb_sync_fifo_param
//  Self-checking bench driving a standard-mode and an FWFT-mode FIFO in parallel.
//  Revision: 1.0
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst, wreq, rreq;
    logic [DW-1:0] wdata;

    logic          s_wfull, s_waf, s_rvalid, s_rempty, s_rae, s_ovf, s_unf;
    logic [DW-1:0] s_rdata;
    logic [4:0]    s_count;
    logic          f_wfull, f_waf, f_rvalid, f_rempty, f_rae, f_ovf, f_unf;
    logic [DW-1:0] f_rdata;
    logic [4:0]    f_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf, m_rvalid;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .wfull(s_wfull),
        .walmost_full(s_waf), .rreq(rreq), .rdata(s_rdata), .rvalid(s_rvalid),
        .rempty(s_rempty), .ralmost_empty(s_rae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .wfull(f_wfull),
        .walmost_full(f_waf), .rreq(rreq), .rdata(f_rdata), .rvalid(f_rvalid),
        .rempty(f_rempty), .ralmost_empty(f_rae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        int  n;
        logic full, empty;
        n     = mq.size();
        full  = (n == DP);
        empty = (n == 0);
        if (r) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end else begin
            m_rvalid = rd && !empty;
            if (rd && !empty) m_rdata = mq.pop_front();
            if (w && !full) mq.push_back(d);
            if (w && full)  m_ovf = 1'b1;
            if (rd && empty) m_unf = 1'b1;
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("std_count",  int'(s_count), n);
        chk("fwft_count", int'(f_count), n);
        chk("std_wfull",  int'(s_wfull),  int'(n == DP));
        chk("fwft_wfull", int'(f_wfull),  int'(n == DP));
        chk("std_waf",    int'(s_waf),    int'(n >= 14));
        chk("fwft_waf",   int'(f_waf),    int'(n >= 14));
        chk("std_rempty", int'(s_rempty), int'(n == 0));
        chk("fwft_rempty",int'(f_rempty), int'(n == 0));
        chk("std_rae",    int'(s_rae),    int'(n <= 2));
        chk("fwft_rae",   int'(f_rae),    int'(n <= 2));
        chk("std_ovf",    int'(s_ovf),    int'(m_ovf));
        chk("fwft_ovf",   int'(f_ovf),    int'(m_ovf));
        chk("std_unf",    int'(s_unf),    int'(m_unf));
        chk("fwft_unf",   int'(f_unf),    int'(m_unf));
        chk("std_rvalid", int'(s_rvalid), int'(m_rvalid));
        chk("std_rdata",  int'(s_rdata),  int'(m_rdata));
        chk("fwft_rvalid",int'(f_rvalid), int'(n != 0));
        if (n != 0) chk("fwft_rdata", int'(f_rdata), int'(mq[0]));
    endtask

    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        rst   = r;
        wreq  = w;
        wdata = d;
        rreq  = rd;
        @(posedge clk);
        model_update(r, w, d, rd);
        #1;
        check_model();
    endtask

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        int            cnt;
        int            s_rdata;
        logic          s_rvalid;
        logic          empty;
        int            head;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic          w, r;
        logic [DW-1:0] d;

        tbl[0] = '{1'b1, 8'd4,   1'b0, 4, 0,   1'b0, 1'b0, 4};
        tbl[0].cnt = 1;
        tbl[1] = '{1'b1, 8'd15,  1'b0, 2, 0,   1'b0, 1'b0, 4};
        tbl[2] = '{1'b1, 8'd19,  1'b0, 3, 0,   1'b0, 1'b0, 4};
        tbl[3] = '{1'b1, 8'd107, 1'b0, 4, 0,   1'b0, 1'b0, 4};
        tbl[4] = '{1'b0, 8'd0,   1'b1, 3, 4,   1'b1, 1'b0, 15};
        tbl[5] = '{1'b0, 8'd0,   1'b1, 2, 15,  1'b1, 1'b0, 19};
        tbl[6] = '{1'b0, 8'd0,   1'b1, 1, 19,  1'b1, 1'b0, 107};
        tbl[7] = '{1'b0, 8'd0,   1'b1, 0, 107, 1'b1, 1'b1, 0};
        tbl[8] = '{1'b0, 8'd0,   1'b0, 0, 107, 1'b0, 1'b1, 0};

        rst = 1'b1; wreq = 1'b0; rreq = 1'b0; wdata = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

        // Reset state
        step(1'b1, 1'b0, 8'd0, 1'b0);
        chk("rst_count", int'(s_count), 0);
        chk("rst_rempty", int'(f_rempty), 1);
        chk("rst_rdata", int'(s_rdata), 0);

        // Ordered write/read table
        for (int i = 0; i < 9; i++) begin
            step(1'b0, tbl[i].w, tbl[i].d, tbl[i].r);
            chk("tbl_count_std",  int'(s_count),  tbl[i].cnt);
            chk("tbl_count_fwft", int'(f_count),  tbl[i].cnt);
            chk("tbl_rdata_std",  int'(s_rdata),  tbl[i].s_rdata);
            chk("tbl_rvalid_std", int'(s_rvalid), int'(tbl[i].s_rvalid));
            chk("tbl_rempty",     int'(s_rempty), int'(tbl[i].empty));
            if (!tbl[i].empty) chk("tbl_head_fwft", int'(f_rdata), tbl[i].head);
        end

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_waf", int'(s_waf), int'(i + 1 >= 14));
        end
        chk("fill_wfull", int'(f_wfull), 1);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("ovf_count", int'(s_count), 16);
        chk("ovf_flag", int'(s_ovf), 1);

        // Full: simultaneous write+read -> read only
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("full_rw_count", int'(f_count), 15);
        chk("full_rw_rdata", int'(s_rdata), 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 8'd0, 1'b1);
            chk("drain_rdata", int'(s_rdata), i);
        end

        // Empty: simultaneous write+read -> write only, underflow
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'd5, 1'b1);
        chk("empty_rw_count", int'(s_count), 1);
        chk("empty_rw_unf", int'(f_unf), 1);
        chk("empty_rw_head", int'(f_rdata), 5);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        chk("empty_rw_read", int'(s_rdata), 5);

        // Steady occupancy across pointer wrap, then mid-stream reset
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b1);
            chk("steady_count", int'(s_count), 8);
        end
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("midrst_count", int'(f_count), 0);
        chk("midrst_rempty", int'(s_rempty), 1);
        chk("midrst_flags", int'({s_ovf, s_unf, f_ovf, f_unf}), 0);

        // Randomised traffic with shifting write bias and an inserted reset
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = (i < 150) ? 70 : (i < 300) ? 30 : (i < 450) ? 85 : 20;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < 50);
            d  = 8'($urandom);
            step((i == 320), w, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
